// File: rtl/demux16_pkg.sv
// demux16_pkg
//   Shared constants and types for the 1-to-16 sequential demultiplexer.
//   CH_NUM     : number of output channels
//   SEL_W      : width of the channel select
//   DATA_W_DEF : default data word width
//   state_e    : top-level FSM states (IDLE accepts words, SWEEP broadcasts)
package demux16_pkg;

  localparam int CH_NUM     = 16;
  localparam int SEL_W      = 4;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/demux16_chan.sv
// demux16_chan
//   One-entry holding register for a single output channel.
//   A write always wins over a simultaneous ack, so a consumer that acks
//   in the same cycle as a new word arrives simply sees the new word.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   wr_en_i   : load wr_data_i and mark the entry valid
//   wr_data_i : word to store
//   ack_i     : consumer takes the current word (clears valid unless written)
//   data_o    : stored word (held after an ack)
//   valid_o   : entry holds an unread word
module demux16_chan #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              ack_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (wr_en_i) begin
      data_d  = wr_data_i;
      valid_d = 1'b1;
    end else if (ack_i) begin
      // An ack on an already-empty entry leaves it empty.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux16_seq.sv
// demux16_seq
//   Sequential 1-to-16 demultiplexer. A unicast word is steered to the
//   channel named by in_sel; a broadcast word is latched and copied to
//   channels 0..15 one per cycle, stalling on any channel that is still
//   occupied and not being acked.
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : producer offers a word
//   in_ready  : word is accepted this cycle (independent of in_valid)
//   in_sel    : destination channel for a unicast word
//   in_bcast  : word goes to every channel, in_sel ignored
//   in_data   : input word
//   out_data  : channel k at [k*DATA_W +: DATA_W]
//   out_valid : channel k holds an unread word
//   out_ack   : consumer k takes its word
//   busy      : broadcast sweep in progress
module demux16_seq
  import demux16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic [DATA_W-1:0]        in_data,
  output logic [CH_NUM*DATA_W-1:0] out_data,
  output logic [CH_NUM-1:0]        out_valid,
  input  logic [CH_NUM-1:0]        out_ack,
  output logic                     busy
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sweep_idx_q, sweep_idx_d;
  logic [DATA_W-1:0] sweep_data_q, sweep_data_d;

  logic [CH_NUM-1:0] free;
  logic [CH_NUM-1:0] sel_hot;
  logic [CH_NUM-1:0] idx_hot;
  logic [CH_NUM-1:0] wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              ready_raw;

  // A channel can take a word this cycle if it is empty or being drained.
  assign free = ~out_valid | out_ack;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_decode
      assign sel_hot[gi] = (in_sel == SEL_W'(gi));
      assign idx_hot[gi] = (sweep_idx_q == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    sweep_idx_d  = sweep_idx_q;
    sweep_data_d = sweep_data_q;
    wr_en        = '0;
    wr_data      = in_data;
    ready_raw    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_bcast) begin
          ready_raw = 1'b1;
          if (in_valid) begin
            sweep_data_d = in_data;
            sweep_idx_d  = '0;
            state_d      = SWEEP;
          end
        end else begin
          ready_raw = free[in_sel];
          if (in_valid && free[in_sel]) begin
            wr_en = sel_hot;
          end
        end
      end
      SWEEP: begin
        wr_data = sweep_data_q;
        if (free[sweep_idx_q]) begin
          wr_en       = idx_hot;
          // Index wraps 15 -> 0 naturally, leaving it ready for the next sweep.
          sweep_idx_d = sweep_idx_q + SEL_W'(1);
          if (sweep_idx_q == SEL_W'(CH_NUM - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sweep_idx_q  <= '0;
      sweep_data_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_idx_q  <= sweep_idx_d;
      sweep_data_q <= sweep_data_d;
    end
  end

  // Gate with rst_n so the producer never sees ready while reset is held.
  assign in_ready = rst_n & ready_raw;
  assign busy     = (state_q == SWEEP);

  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_chan
      demux16_chan #(
        .DATA_W (DATA_W)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en[gi]),
        .wr_data_i (wr_data),
        .ack_i     (out_ack[gi]),
        .data_o    (out_data[gi*DATA_W +: DATA_W]),
        .valid_o   (out_valid[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux16_seq.sv
// tb_demux16_seq
//   Table-driven unicast/collision vectors, hand-written broadcast, stall
//   and mid-sweep reset sequences, then randomized traffic. A behavioural
//   model (per-channel arrays plus a queue of channels still owed a
//   broadcast word) is compared against the DUT on every falling edge.
module tb_demux16_seq;

  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_bcast = 1'b0;
  logic [3:0]      in_sel = '0;
  logic [DW-1:0]   in_data = '0;
  logic [15:0]     out_ack = '0;
  logic            in_ready;
  logic            busy;
  logic [16*DW-1:0] out_data;
  logic [15:0]     out_valid;

  always #5 clk = ~clk;

  demux16_seq #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .busy      (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [15:0]   m_valid = '0;
  logic [DW-1:0] m_data [16];
  logic [DW-1:0] m_bword = '0;
  int            owed_q[$];   // channels still waiting for the broadcast word

  function automatic logic [15:0] m_free();
    return ~m_valid | out_ack;
  endfunction

  function automatic logic m_ready();
    logic [15:0] f;
    if (!rst_n || owed_q.size() != 0) return 1'b0;
    if (in_bcast) return 1'b1;
    f = m_free();
    return f[in_sel];
  endfunction

  logic [15:0] mf;
  logic        mr;
  int          mc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = '0;
      for (int k = 0; k < 16; k++) m_data[k] = '0;
      m_bword = '0;
      owed_q.delete();
    end else begin
      mf = m_free();
      mr = m_ready();
      m_valid = m_valid & ~out_ack;
      if (owed_q.size() != 0) begin
        mc = owed_q[0];
        if (mf[mc]) begin
          m_valid[mc] = 1'b1;
          m_data[mc]  = m_bword;
          void'(owed_q.pop_front());
        end
      end else if (in_valid && mr) begin
        if (in_bcast) begin
          m_bword = in_data;
          for (int k = 0; k < 16; k++) owed_q.push_back(k);
        end else begin
          m_valid[in_sel] = 1'b1;
          m_data[in_sel]  = in_data;
        end
      end
    end
  end

  logic [16*DW-1:0] exp_flat;
  always @(negedge clk) begin
    for (int k = 0; k < 16; k++) exp_flat[k*DW +: DW] = m_data[k];
    chk("model_valid", out_valid, m_valid);
    chk("model_data", out_data, exp_flat);
    chk("model_busy", busy, (owed_q.size() != 0));
    chk("model_ready", in_ready, m_ready());
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs a sweep already accepted; counts busy cycles. ack7_at: cycle in
  // which channel 7 is acked (-1 = never); peek_at: cycle to check stall.
  task automatic run_sweep(input int ack7_at, input int peek_at, output int cnt);
    bit done = 0;
    cnt = 0;
    for (int j = 0; j < 60; j++) begin
      out_ack = (j == ack7_at) ? 16'h0080 : 16'h0000;
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
      cnt++;
      if (j == peek_at) begin
        chk("stall_valid", out_valid, 16'h00FF);
        chk("stall_busy", busy, 1'b1);
        chk("stall_ch7", out_data[7*DW +: DW], 16'h7777);
      end
      step();
    end
    out_ack = '0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sweep_timeout: busy still %0b after 60 cycles, want 0", busy);
    end
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    logic [15:0] ack;
    logic        exp_ready;
    logic [15:0] exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // Table: unicast fill of all 16 channels, then blocked/collision cases.
    for (int k = 0; k < 16; k++)
      vt.push_back('{sel: 4'(k), data: 16'hA000 + 16'(k), ack: 16'h0,
                     exp_ready: 1'b1, exp_valid: 16'hFFFF >> (15 - k),
                     exp_data: 16'hA000 + 16'(k)});
    vt.push_back('{sel: 4'd3, data: 16'h3333, ack: 16'h0000, exp_ready: 1'b0,
                   exp_valid: 16'hFFFF, exp_data: 16'hA003});
    vt.push_back('{sel: 4'd5, data: 16'h1111, ack: 16'h0020, exp_ready: 1'b1,
                   exp_valid: 16'hFFFF, exp_data: 16'h1111});
    vt.push_back('{sel: 4'd5, data: 16'h2222, ack: 16'h0060, exp_ready: 1'b1,
                   exp_valid: 16'hFFBF, exp_data: 16'h2222});
    vt.push_back('{sel: 4'd6, data: 16'h6666, ack: 16'h0000, exp_ready: 1'b1,
                   exp_valid: 16'hFFFF, exp_data: 16'h6666});

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      in_bcast = 1'($urandom);
      in_sel   = 4'($urandom);
      in_data  = 16'($urandom);
      out_ack  = 16'($urandom);
      @(negedge clk);
      chk("rst_valid", out_valid, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
      step();
    end
    in_valid = 0; in_bcast = 0; in_sel = 0; in_data = 0; out_ack = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_data", out_data, '0);
    $display("reset: out_valid=%h busy=%0b", out_valid, busy);
    step();

    // Table-driven unicast vectors.
    foreach (vt[i]) begin
      in_valid = 1'b1;
      in_bcast = 1'b0;
      in_sel   = vt[i].sel;
      in_data  = vt[i].data;
      out_ack  = vt[i].ack;
      @(negedge clk);
      chk("vec_ready", in_ready, vt[i].exp_ready);
      step();
      in_valid = 1'b0;
      out_ack  = '0;
      chk("vec_valid", out_valid, vt[i].exp_valid);
      chk("vec_data", out_data[vt[i].sel*DW +: DW], vt[i].exp_data);
      $display("unicast sel=%0d data=%h ack=%h -> valid=%h ch=%h", vt[i].sel,
               vt[i].data, vt[i].ack, out_valid, out_data[vt[i].sel*DW +: DW]);
    end
    out_ack = 16'hFFFF;
    step();
    out_ack = '0;
    chk("drain_valid", out_valid, 16'h0000);

    // Broadcast into empty channels.
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'hBEEF;
    @(negedge clk);
    chk("bc_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    run_sweep(-1, -1, cnt);
    chk("bc_busy_cycles", 32'(cnt), 32'd16);
    chk("bc_ready_after", in_ready, 1'b1);
    chk("bc_valid", out_valid, 16'hFFFF);
    chk("bc_data", out_data, {16{16'hBEEF}});
    $display("broadcast BEEF: busy_cycles=%0d valid=%h", cnt, out_valid);
    step();
    in_bcast = 1'b0;
    out_ack  = 16'hFFFF;
    step();
    out_ack = '0;

    // Broadcast stalled on channel 7 for 5 cycles.
    in_valid = 1'b1; in_sel = 4'd7; in_data = 16'h7777;
    step();
    in_bcast = 1'b1; in_data = 16'hCAFE;
    step();
    in_valid = 1'b0; in_bcast = 1'b0;
    run_sweep(12, 11, cnt);
    chk("stall_busy_cycles", 32'(cnt), 32'd21);
    chk("stall_valid_end", out_valid, 16'hFFFF);
    chk("stall_data_end", out_data, {16{16'hCAFE}});
    $display("broadcast CAFE stalled: busy_cycles=%0d valid=%h", cnt, out_valid);
    step();
    out_ack = 16'hFFFF;
    step();
    out_ack = '0;

    // Reset in the middle of a sweep (at index 9).
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'h1234;
    step();
    in_valid = 1'b0; in_bcast = 1'b0;
    for (int j = 0; j < 9; j++) step();
    chk("mid_valid_pre", out_valid, 16'h01FF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 16'h0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 4'd2; in_data = 16'h5A5A;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 16'h0004);
    chk("post_rst_data", out_data[2*DW +: DW], 16'h5A5A);
    $display("reset mid-sweep then unicast sel=2: valid=%h", out_valid);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom);
      in_bcast = ($urandom_range(0, 39) == 0);
      in_sel   = 4'($urandom);
      in_data  = 16'($urandom);
      out_ack  = 16'($urandom) & 16'($urandom);
      step();
    end
    in_valid = 0; in_bcast = 0; out_ack = 0;
    step();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
